// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one lookahead group of BLOCK bits per register stage.
// Optional macro CLA_PIPE_SAT_EN adds signed saturation of the sum in the last stage.
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLOCK;

    if (BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_param_check
        $error("cla_adder_pipe: WIDTH must be a multiple of BLOCK and BLOCK within 1..WIDTH");
    end

    // Handshake: a beat moves on a side when valid & ready are both high on a rising edge.
    // The whole pipeline advances together; it freezes only when a result is held (out_valid & ~out_ready).
    logic adv;
    assign adv       = ~(out_valid & ~out_ready);
    assign in_ready  = adv;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | c_in;

    // x word: finished sum bits below the current group, untouched A bits above it.
    // y word: remaining effective-B bits, right-aligned so the current group sits at [BLOCK-1:0].
    logic [WIDTH-1:0] x_d [NBLK];
    logic [WIDTH-1:0] x_q [NBLK];
    logic [WIDTH-1:0] y_d [NBLK];
    logic [WIDTH-1:0] y_q [NBLK];
    logic             c_d [NBLK];
    logic             c_q [NBLK];
    logic             v_q [NBLK];
    logic             ovf_d;
    logic             ovf_q;

    function automatic logic [BLOCK:0] group_carries(
        input logic [BLOCK-1:0] g,
        input logic [BLOCK-1:0] p,
        input logic             ci
    );
        logic [BLOCK:0] c;
        logic           run;
        c    = '0;
        run  = 1'b1;
        c[0] = ci;
        for (int j = 1; j <= BLOCK; j++) begin
            run  = 1'b1;
            c[j] = 1'b0;
            for (int m = j - 1; m >= 0; m--) begin
                c[j] = c[j] | (run & g[m]);
                run  = run & p[m];
            end
            c[j] = c[j] | (run & ci);
        end
        return c;
    endfunction

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        localparam int LO = k * BLOCK;

        logic [WIDTH-1:0] xi;
        logic [WIDTH-1:0] yi;
        logic             ci;
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic [WIDTH-1:0] xn;

        if (k == 0) begin : g_head
            assign xi = a;
            assign yi = b_eff;
            assign ci = cin_eff;
        end else begin : g_body
            assign xi = x_q[k-1];
            assign yi = y_q[k-1];
            assign ci = c_q[k-1];
        end

        assign g = xi[LO +: BLOCK] & yi[BLOCK-1:0];
        assign p = xi[LO +: BLOCK] ^ yi[BLOCK-1:0];
        assign c = group_carries(g, p, ci);

        assign y_d[k] = yi >> BLOCK;
        assign c_d[k] = c[BLOCK];
        assign x_d[k] = xn;

        if (k == NBLK - 1) begin : g_last
            assign ovf_d = c[BLOCK] ^ c[BLOCK-1];
`ifdef CLA_PIPE_SAT_EN
            // On overflow both effective MSBs agree; A's MSB picks the saturation direction.
            always_comb begin
                xn               = xi;
                xn[LO +: BLOCK]  = p ^ c[BLOCK-1:0];
                if (ovf_d) begin
                    xn = {xi[WIDTH-1], {(WIDTH-1){~xi[WIDTH-1]}}};
                end
            end
`else
            always_comb begin
                xn              = xi;
                xn[LO +: BLOCK] = p ^ c[BLOCK-1:0];
            end
`endif
        end else begin : g_mid
            always_comb begin
                xn              = xi;
                xn[LO +: BLOCK] = p ^ c[BLOCK-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NBLK; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NBLK; k++) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
                c_q[k] <= c_d[k];
            end
            v_q[0] <= in_valid;
            for (int k = 1; k < NBLK; k++) begin
                v_q[k] <= v_q[k-1];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[NBLK-1];
    assign sum       = x_q[NBLK-1];
    assign c_out     = c_q[NBLK-1];
    assign ovf       = ovf_q;

endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the team's 4-bit combinational CLA cell.
- The operand is split into groups of BLOCK bits. Each group is a full lookahead stage (group generate/propagate plus internal lookahead carries), and one register stage sits between consecutive groups.
- Valid/ready handshakes on both sides. Intended as the datapath adder for wide accumulators and address generators, where a single-cycle wide CLA cannot close timing.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be an exact multiple of BLOCK (elaboration error otherwise).
- BLOCK, 4, bits per lookahead group; range 1..WIDTH.
- NBLK, WIDTH/BLOCK (derived, not overridable), number of pipeline stages = latency in cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A (unsigned or two's complement)
- b  in  WIDTH  operand B
- c_in  in  1  carry-in; used only when sub=0
- sub  in  1  0: A+B+c_in; 1: A-B (= A + ~B + 1)
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- c_out  out  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- One clock; reset is asynchronous and active-high.
- Global advance enable: adv = ~(out_valid & ~out_ready). in_ready = adv. Combinational from out_valid/out_ready only; no path from in_valid.
- Beat accepted when in_valid & in_ready. On acceptance, stage 0 registers:
  - effective B: b, or ~b when sub=1;
  - effective carry-in: c_in, or 1 when sub=1;
  - remaining operand slices.
- Stage k (0..NBLK-1):
  - computes bit-level g = a&b' and p = a^b' for group k;
  - computes group lookahead carries from the stage's registered carry-in;
  - computes sum bits s_i = p_i ^ c_i;
  - passes the group carry-out, the completed lower sum bits and the untouched upper operand slices to stage k+1 on adv.
- Each stage has a valid bit. When adv=1, all stages shift by one: stage 0 valid takes in_valid & in_ready. When adv=0, every register holds (full pipeline stall, no bubbles collapsed).
- out_valid = valid bit of last stage. sum/c_out/ovf are registered outputs of the last stage and stay stable while out_valid & ~out_ready.
- ovf is computed in the last stage from carry into bit WIDTH-1 and carry out of bit WIDTH-1.
- Latency: NBLK cycles from acceptance to out_valid with no stall. Throughput: 1 beat/cycle while out_ready=1.
- NBLK=1 (BLOCK=WIDTH): single registered stage, latency 1.
- Results leave in acceptance order; no reordering, no drops, no duplication.
- Reset (asynchronous, any time including mid-flight):
  - all stage valid bits → 0 and all data registers → 0;
  - in-flight beats are discarded;
  - outputs read out_valid=0, sum=0, c_out=0, ovf=0. in_ready=1 during and after reset.
- Wrap-around: results are modulo 2^WIDTH (e.g. 0xFFFF+0x0001 → sum=0x0000, c_out=1).
- Bubbles (in_valid=0 while adv=1) propagate as invalid stages; the data content of bubbles is don't-care but must not raise out_valid.

Optional Feature:
- Macro CLA_PIPE_SAT_EN.
- Defined: last stage applies signed saturation when ovf=1.
  - Positive overflow (both effective operands' MSBs 0) → sum = 0111…1.
  - Negative overflow → sum = 1000…0.
  - c_out and ovf are still reported unmodified; latency unchanged.
- Undefined: sum wraps modulo 2^WIDTH; no saturation logic is generated.

Test Plan (WIDTH=16, BLOCK=4, so latency 4):
- Basic add: a=0x1234, b=0x0FFF, c_in=1, sub=0, out_ready=1 → 4 cycles later out_valid=1, sum=0x2234, c_out=0, ovf=0.
- Wrap and subtract: beat1 a=0xFFFF, b=0x0001, sub=0 → sum=0x0000, c_out=1, ovf=0. Beat2 a=0x0003, b=0x0005, sub=1, c_in=0 → sum=0xFFFE, c_out=0, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 → ovf=1, c_out=0. Sum=0x8000 without macro, 0x7FFF with CLA_PIPE_SAT_EN.
- Back-to-back and backpressure:
  - stream 8 beats, where operand i is a=i, b=0x0100; deassert out_ready for 3 cycles after the first result;
  - required: in_ready=0 exactly during those cycles, out data held stable, all 8 results (0x0100+i) in order, no loss/duplicate.
- Bubbles: alternate in_valid 1/0 for 6 cycles → out_valid pattern repeats 1/0 delayed by 4 cycles.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle asynchronously between clock edges → out_valid=0, sum=0 immediately. None of the 3 beats ever appear. A new beat after reset returns the correct result after 4 cycles.
